// File: rtl/layer_mac_scheduler.sv
// layer_mac_scheduler
//   Time-multiplexed sequencer for one fully-connected layer. A single shared
//   32-bit MAC walks every neuron in turn. For each neuron it reads the bias,
//   weights and activations from synchronous memories and accumulates them in
//   Q.FRAC fixed point. It then applies ReLU, truncates to a 16-bit node value
//   and presents the result on a valid/ready port. done pulses once, after the
//   last neuron has been accepted.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               begin a layer (sampled only while idle)
//   busy, done          layer in progress / one-cycle completion pulse
//   mem_rd              shared read strobe for activation/weight/bias memories
//   act_addr/act_data   activation index i, data returned one cycle later
//   w_addr/w_data       weight index n*NUM_IN+i, signed, one cycle later
//   b_addr/b_data       bias index n, signed, one cycle later
//   out_valid/out_ready result handshake
//   out_idx/out_data    neuron index and zero-extended ReLU'd result
module layer_mac_scheduler #(
  parameter int unsigned NUM_IN  = 15,
  parameter int unsigned NUM_OUT = 16,
  parameter int unsigned FRAC    = 13,
  parameter int unsigned AW_A    = 4,
  parameter int unsigned AW_W    = 8,
  parameter int unsigned AW_B    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            mem_rd,
  output logic [AW_A-1:0] act_addr,
  input  logic [31:0]     act_data,
  output logic [AW_W-1:0] w_addr,
  input  logic [31:0]     w_data,
  output logic [AW_B-1:0] b_addr,
  input  logic [31:0]     b_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW_B-1:0] out_idx,
  output logic [31:0]     out_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC  = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [AW_B-1:0] n_q, n_d;
  logic [AW_A-1:0] i_q, i_d;
  // Weight address runs linearly across neurons: the address after
  // n*NUM_IN+(NUM_IN-1) is (n+1)*NUM_IN+0, so no multiplier is needed.
  logic [AW_W-1:0] w_q, w_d;
  logic [31:0]     acc_q, acc_d;
  // Pipeline stage: an issue happened last cycle; its data is on the buses now.
  logic            pv_q, pv_d;
  logic            pfirst_q, pfirst_d;
  logic [31:0]     prod;

  // Low 32 bits of a product are identical for signed and unsigned operands.
  assign prod = act_data * w_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      i_q      <= '0;
      w_q      <= '0;
      acc_q    <= '0;
      pv_q     <= 1'b0;
      pfirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      i_q      <= i_d;
      w_q      <= w_d;
      acc_q    <= acc_d;
      pv_q     <= pv_d;
      pfirst_q <= pfirst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    w_d      = w_q;
    acc_d    = acc_q;
    pv_d     = 1'b0;
    pfirst_d = 1'b0;

    // The first element of each neuron seeds the accumulator with the bias.
    if (pv_q) begin
      acc_d = (pfirst_q ? b_data : acc_q) + prod;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          n_d     = '0;
          i_d     = '0;
          w_d     = '0;
        end
      end
      S_MAC: begin
        pv_d     = 1'b1;
        pfirst_d = (i_q == '0);
        w_d      = w_q + 1'b1;
        if (i_q == AW_A'(NUM_IN - 1)) begin
          i_d     = '0;
          state_d = S_LAST;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_LAST: begin
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (n_q == AW_B'(NUM_OUT - 1)) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + 1'b1;
            i_d     = '0;
            state_d = S_MAC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign mem_rd    = (state_q == S_MAC);
  assign act_addr  = mem_rd ? i_q : '0;
  assign w_addr    = mem_rd ? w_q : '0;
  assign b_addr    = mem_rd ? n_q : '0;
  assign out_valid = (state_q == S_EMIT);
  assign out_idx   = out_valid ? n_q : '0;
  assign out_data  = (out_valid && !acc_q[31]) ? {16'b0, acc_q[FRAC+15:FRAC]} : '0;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Testbench for layer_mac_scheduler (NUM_IN=15, NUM_OUT=2). It uses a
// scoreboard queue of expected {idx, data} results and behavioural
// synchronous memories.
module tb_layer_mac_scheduler;
  localparam int NI = 15;
  localparam int NO = 2;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic        busy, done, mem_rd, out_valid;
  logic [3:0]  act_addr, b_addr, out_idx;
  logic [7:0]  w_addr;
  logic [31:0] act_data = '0, w_data = '0, b_data = '0, out_data;

  logic [31:0] act_mem [0:15];
  logic [31:0] w_mem   [0:255];
  logic [31:0] b_mem   [0:15];
  logic [35:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  layer_mac_scheduler #(
    .NUM_IN(NI), .NUM_OUT(NO), .FRAC(13), .AW_A(4), .AW_W(8), .AW_B(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .act_addr(act_addr), .act_data(act_data),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      act_data <= act_mem[act_addr];
      w_data   <= w_mem[w_addr];
      b_data   <= b_mem[b_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [31:0] a, input logic [31:0] w, input logic [31:0] b);
    for (int i = 0; i < 16; i++) act_mem[i] = a;
    for (int j = 0; j < 256; j++) w_mem[j] = w;
    for (int k = 0; k < 16; k++) b_mem[k] = b;
  endtask

  function automatic logic [31:0] model(input int n);
    logic [31:0] acc;
    acc = b_mem[n];
    for (int i = 0; i < NI; i++) acc = acc + act_mem[i] * w_mem[n*NI+i];
    return acc[31] ? 32'd0 : {16'b0, acc[28:13]};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_memrd"}, mem_rd, 0);
    check({tag, "_aaddr"}, act_addr, 0);
    check({tag, "_waddr"}, w_addr, 0);
    check({tag, "_baddr"}, b_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  // Runs one layer starting from IDLE; all sampling is at the falling edge.
  task automatic run_layer(input int stall, input bit repulse);
    int cyc, exp_i, exp_n, stall_left, done_cnt, done_cyc, k;
    bit prev_hs, held_set;
    logic [3:0]  h_idx;
    logic [31:0] h_data;
    logic [35:0] e;
    exp_i = 0; exp_n = 0; stall_left = stall; done_cnt = 0; done_cyc = -1;
    k = 0; prev_hs = 0; held_set = 0; h_idx = '0; h_data = '0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 150) begin
      start = repulse && (cyc == 5 || cyc == 20);
      if (prev_hs) check("issue_after_hs", mem_rd, 1);
      prev_hs = 0;
      if (mem_rd) begin
        check("act_addr", act_addr, exp_i);
        check("w_addr", w_addr, exp_n*NI + exp_i);
        check("b_addr", b_addr, exp_n);
        exp_i++;
        if (exp_i == NI) begin exp_i = 0; exp_n++; end
      end
      if (out_valid) begin
        if (!held_set) begin
          check("emit_cycle", cyc, 17*(k+1) + ((k > 0) ? stall : 0));
          h_idx = out_idx; h_data = out_data; held_set = 1;
        end else begin
          check("hold_idx", out_idx, h_idx);
          check("hold_data", out_data, h_data);
        end
        if (stall_left > 0 && k == 0) begin
          out_ready = 1'b0;
          check("stall_memrd", mem_rd, 0);
          stall_left--;
        end else begin
          out_ready = 1'b1;
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=empty expected=entry");
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_idx", out_idx, e[35:32]);
            check("out_data", out_data, e[31:0]);
          end
          prev_hs = (k < NO-1);
          k++;
          held_set = 0;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
      end else if (done_cyc < 0) begin
        check("busy_high", busy, 1);
      end else begin
        check("idle_busy", busy, 0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_cycle", done_cyc, 35 + stall);
    check("done_count", done_cnt, 1);
    check("emit_count", k, NO);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    fill_const(32'd8192, 32'd1, 32'd392);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Scenario 1: acc = 392 + 15*8192 = 123272 -> 15
    exp_q.push_back({4'd0, 32'd15});
    exp_q.push_back({4'd1, 32'd15});
    run_layer(0, 1'b0);

    // Scenarios 2 and 5: negative accumulator clamps to 0; extra starts ignored
    fill_const(32'd8192, 32'hFFFF_E000, 32'd0);
    exp_q.push_back({4'd0, 32'd0});
    exp_q.push_back({4'd1, 32'd0});
    run_layer(0, 1'b1);

    // Scenario 3/4: random data, 5-cycle stall on neuron 0
    for (int i = 0; i < 16; i++) act_mem[i] = $urandom_range(0, 16383);
    for (int j = 0; j < 256; j++) w_mem[j] = 32'($signed($urandom_range(0, 16384)) - 8192);
    for (int m = 0; m < 16; m++) b_mem[m] = 32'($urandom_range(0, 65535));
    exp_q.push_back({4'd0, model(0)});
    exp_q.push_back({4'd1, model(1)});
    run_layer(5, 1'b0);

    // Scenario 6: reset during the 8th MAC cycle of neuron 0
    fill_const(32'd8192, 32'd1, 32'd392);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_memrd", mem_rd, 1);
    check("pre_reset_aaddr", act_addr, 7);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
    end
    exp_q.push_back({4'd0, 32'd15});
    exp_q.push_back({4'd1, 32'd15});
    run_layer(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
